serial_word_collector: RTL and testbench

//   Assembles a WIDTH-bit word from a serial bit stream and presents it to the

---
 rtl/serial_word_collector.sv | 115 +++++++++++
 tb/tb_serial_word_collector.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector: explicit start, WIDTH bits shifted in,
// finished word held under valid/ready; bits arriving while holding are flagged.
module serial_word_collector #(
  parameter int WIDTH     = 5,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             busy,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;
  logic [WIDTH-1:0]  shreg, shreg_next;
  logic [WIDTH-1:0]  word_next;
  logic [WIDTH-1:0]  shifted;
  logic              valid_next;
  logic              overrun_next;
  logic              busy_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shreg      <= shreg_next;
      word_out   <= word_next;
      word_valid <= valid_next;
      overrun    <= overrun_next;
      busy       <= busy_next;
    end
  end

  // Accepting start (from IDLE, or from HOLD alongside the handshake) always
  // begins a clean word and clears the sticky overrun flag.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shreg_next   = shreg;
    word_next    = word_out;
    valid_next   = word_valid;
    overrun_next = overrun;
    shifted      = MSB_FIRST ? {shreg[WIDTH-2:0], ser_in}
                             : {ser_in, shreg[WIDTH-1:1]};

    case (state)
      IDLE: begin
        if (start) begin
          state_next   = SHIFT;
          cnt_next     = '0;
          shreg_next   = '0;
          overrun_next = 1'b0;
        end
      end
      SHIFT: begin
        if (ser_valid) begin
          shreg_next = shifted;
          if (cnt == LAST_BIT) begin
            cnt_next   = '0;
            word_next  = shifted;
            valid_next = 1'b1;
            state_next = HOLD;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        if (ser_valid) begin
          overrun_next = 1'b1;
        end
        if (word_ready) begin
          valid_next = 1'b0;
          if (start) begin
            state_next   = SHIFT;
            cnt_next     = '0;
            shreg_next   = '0;
            overrun_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next == SHIFT);
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector: one MSB-first and one
// LSB-first instance share stimulus; a scoreboard holds expected words.
module tb_serial_word_collector;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       ser_in;
  logic       ser_valid;
  logic       word_ready;

  logic       busy, word_valid, overrun;
  logic [4:0] word_out;
  logic       busy_lsb, word_valid_lsb, overrun_lsb;
  logic [4:0] word_out_lsb;

  int checks   = 0;
  int failures = 0;

  logic [4:0] q_msb[$];
  logic [4:0] q_lsb[$];

  serial_word_collector #(.WIDTH(5), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in),
    .ser_valid(ser_valid), .busy(busy), .word_out(word_out),
    .word_valid(word_valid), .word_ready(word_ready), .overrun(overrun)
  );

  serial_word_collector #(.WIDTH(5), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start), .ser_in(ser_in),
    .ser_valid(ser_valid), .busy(busy_lsb), .word_out(word_out_lsb),
    .word_valid(word_valid_lsb), .word_ready(word_ready), .overrun(overrun_lsb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h required=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [4:0] rev5(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic accept();
    word_ready = 1'b1;
    cycle();
    word_ready = 1'b0;
  endtask

  // bits[4] goes first on the wire; gapAfter[k] inserts an idle cycle after that bit
  task automatic applyStimulus(input logic [4:0] bits, input logic [4:0] gapAfter);
    for (int i = 0; i < 5; i++) begin
      ser_valid = 1'b1;
      ser_in    = bits[4-i];
      if (i == 4) begin
        q_msb.push_back(bits);
        q_lsb.push_back(rev5(bits));
      end
      cycle();
      if (gapAfter[4-i]) begin
        ser_valid = 1'b0;
        @(negedge clk);
        checkOutput("busy_gap", 32'(busy), 32'd1);
        checkOutput("valid_gap", 32'(word_valid), 32'd0);
        cycle();
      end
    end
    ser_valid = 1'b0;
  endtask

  // Scoreboard monitor: compare on each new word, then require stability while held
  logic       prev_valid = 1'b0;
  logic [4:0] held_msb, held_lsb, exp_m, exp_l;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (word_valid && !prev_valid) begin
        if (q_msb.size() == 0) begin
          checkOutput("sb_underflow", 32'(q_msb.size()), 32'd1);
        end else begin
          exp_m = q_msb.pop_front();
          exp_l = q_lsb.pop_front();
          checkOutput("word_msb", 32'(word_out), 32'(exp_m));
          checkOutput("word_lsb", 32'(word_out_lsb), 32'(exp_l));
          checkOutput("valid_lsb", 32'(word_valid_lsb), 32'd1);
          checkOutput("or_out", 32'(|word_out), 32'(|exp_m));
        end
        held_msb = word_out;
        held_lsb = word_out_lsb;
      end else if (word_valid && prev_valid) begin
        checkOutput("hold_msb", 32'(word_out), 32'(held_msb));
        checkOutput("hold_lsb", 32'(word_out_lsb), 32'(held_lsb));
      end
      prev_valid = word_valid;
    end
  end

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    ser_in     = 1'b0;
    ser_valid  = 1'b0;
    word_ready = 1'b0;

    // Reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_word", 32'(word_out), 32'd0);
    checkOutput("rst_word_lsb", 32'(word_out_lsb), 32'd0);
    #19 rst_n = 1'b1;
    cycle();

    $display("[TB] test 1: bits 0,0,1,0,0");
    doStart();
    @(negedge clk);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    cycle();
    applyStimulus(5'b00100, 5'b00000);
    @(negedge clk);
    checkOutput("t1_valid", 32'(word_valid), 32'd1);
    checkOutput("t1_busy_hold", 32'(busy), 32'd0);
    checkOutput("t1_or", 32'(|word_out), 32'd1);
    accept();

    $display("[TB] test 2: all-zero word, immediate accept");
    doStart();
    applyStimulus(5'b00000, 5'b00000);
    @(negedge clk);
    checkOutput("t2_valid", 32'(word_valid), 32'd1);
    checkOutput("t2_or", 32'(|word_out), 32'd0);
    accept();
    @(negedge clk);
    checkOutput("t2_valid_drop", 32'(word_valid), 32'd0);
    checkOutput("t2_busy", 32'(busy), 32'd0);
    checkOutput("t2_word_kept", 32'(word_out), 32'd0);
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    cycle();
    cycle();
    ser_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_idle_no_overrun", 32'(overrun), 32'd0);
    checkOutput("t2_idle_busy", 32'(busy), 32'd0);
    checkOutput("t2_idle_valid", 32'(word_valid), 32'd0);

    $display("[TB] test 3: bits 1,0,0,0,1 with stalls");
    doStart();
    applyStimulus(5'b10001, 5'b01010);
    @(negedge clk);
    checkOutput("t3_word", 32'(word_out), 32'h11);
    accept();

    $display("[TB] test 4: overrun while holding");
    doStart();
    applyStimulus(5'b11010, 5'b00000);
    for (int i = 0; i < 4; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'($urandom_range(0, 1));
      cycle();
      @(negedge clk);
      checkOutput("t4_valid_held", 32'(word_valid), 32'd1);
      checkOutput("t4_overrun", 32'(overrun), 32'd1);
    end
    ser_valid = 1'b0;
    cycle();
    accept();
    @(negedge clk);
    checkOutput("t4_overrun_after_accept", 32'(overrun), 32'd1);
    checkOutput("t4_overrun_lsb", 32'(overrun_lsb), 32'd1);
    checkOutput("t4_valid_drop", 32'(word_valid), 32'd0);
    checkOutput("t4_word_kept", 32'(word_out), 32'h1A);
    doStart();
    @(negedge clk);
    checkOutput("t4_overrun_cleared", 32'(overrun), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    cycle();
    applyStimulus(5'b00111, 5'b00000);
    accept();

    $display("[TB] test 5: reset mid-word");
    doStart();
    for (int i = 0; i < 3; i++) begin
      ser_valid = 1'b1;
      ser_in    = 1'b1;
      cycle();
    end
    ser_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_valid", 32'(word_valid), 32'd0);
    checkOutput("t5_word", 32'(word_out), 32'd0);
    checkOutput("t5_word_lsb", 32'(word_out_lsb), 32'd0);
    checkOutput("t5_overrun", 32'(overrun), 32'd0);
    #1 rst_n = 1'b1;
    cycle();
    doStart();
    applyStimulus(5'b01101, 5'b00000);
    accept();

    $display("[TB] test 6: LSB-first order and back-to-back start");
    doStart();
    applyStimulus(5'b10000, 5'b00000);
    @(negedge clk);
    checkOutput("t6_word_lsb", 32'(word_out_lsb), 32'h01);
    word_ready = 1'b1;
    start      = 1'b1;
    cycle();
    word_ready = 1'b0;
    start      = 1'b0;
    @(negedge clk);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    checkOutput("t6_busy_lsb", 32'(busy_lsb), 32'd1);
    checkOutput("t6_valid", 32'(word_valid), 32'd0);
    cycle();
    applyStimulus(5'b01011, 5'b00000);
    accept();

    @(negedge clk);
    checkOutput("sb_drain", 32'(q_msb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
